// File: rtl/hidden_prog_feeder_if.sv
// Program-load handshake between host logic and the HiddenCPU program feeder.
// master = host side driving words, slave = feeder accepting them.
interface hidden_prog_feeder_if;
    logic       load_start;
    logic       load_valid;
    logic [5:0] load_data;
    logic       load_ready;

    modport master (
        output load_start,
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/hidden_prog_feeder.sv
// HiddenCPU pin driver: stores a small program and clocks the CPU, fetching by the pc it reports.
// Optional macro HIDDEN_FEEDER_SINGLE_STEP_EN adds step_req_i to gate each CPU step.
//   state  | meaning
//   IDLE   | after reset; loads accepted, CPU held in reset
//   RST    | RST_CYC clock pulses with cpu_rst=1
//   LOW    | cpu_clk low, instr tracks mem[pc]; pc >= prog_len halts on entry
//   HIGH   | cpu_clk high, instr frozen; step counted at end
//   DONE   | run finished; CPU state preserved, loads/runs accepted
module hidden_prog_feeder #(
    parameter int DEPTH    = 16,
    parameter int HALF_CYC = 2,
    parameter int RST_CYC  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hidden_prog_feeder_if.slave  load,
    input  logic                 run_start_i,
    input  logic [7:0]           max_steps_i,
`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
    input  logic                 step_req_i,
`endif
    input  logic [7:0]           cpu_io_out_i,
    output logic [7:0]           cpu_io_in_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 halt_pc_o,
    output logic [7:0]           steps_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WPW = AW + 1;
    localparam int PW  = $clog2(HALF_CYC) + 1;
    localparam int RCW = $clog2(RST_CYC) + 1;
    localparam logic [PW-1:0]  PH_LAST = PW'(HALF_CYC - 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYC - 1);
    localparam logic [WPW-1:0] WP_FULL = WPW'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_LOW, S_HIGH, S_DONE} state_e;

    state_e         state_q;
    logic [PW-1:0]  phase_q;
    logic [RCW-1:0] rst_cnt_q;
    logic           rst_hi_q;
    logic           low_first_q;
    logic [WPW-1:0] wp_q;
    logic [WPW-1:0] prog_len_q;
    logic [7:0]     max_steps_q;
    logic [7:0]     steps_q;
    logic           halt_pc_q;
    logic           cpu_clk_q;
    logic           cpu_rst_q;
    logic [5:0]     instr_q;
    logic [5:0]     mem_q [DEPTH];

    logic           idle_like;
    logic           load_rdy;
    logic           wr_en;
    logic [5:0]     fetch;
    logic           pc_oob;
    logic           step_ok;
    logic [8:0]     steps_inc;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign load_rdy  = idle_like && (wp_q < WP_FULL);
    assign wr_en     = load_rdy && load.load_valid && !load.load_start;
    assign fetch     = mem_q[cpu_io_out_i[AW-1:0]];
    assign pc_oob    = {1'b0, cpu_io_out_i} >= 9'(prog_len_q);
    assign steps_inc = {1'b0, steps_q} + 9'd1;

`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
    logic step_seen_q;
    assign step_ok = step_seen_q || step_req_i;
`else
    assign step_ok = 1'b1;
`endif

    // Program memory is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wp_q[AW-1:0]] <= load.load_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            rst_cnt_q   <= '0;
            rst_hi_q    <= 1'b0;
            low_first_q <= 1'b0;
            wp_q        <= '0;
            prog_len_q  <= '0;
            max_steps_q <= '0;
            steps_q     <= '0;
            halt_pc_q   <= 1'b0;
            cpu_clk_q   <= 1'b0;
            cpu_rst_q   <= 1'b1;
            instr_q     <= '0;
`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
            step_seen_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (load.load_start) begin
                        wp_q       <= '0;
                        prog_len_q <= '0;
                    end else if (wr_en) begin
                        wp_q       <= wp_q + 1'b1;
                        prog_len_q <= wp_q + 1'b1;
                    end
                    if (run_start_i && (prog_len_q != '0)) begin
                        state_q     <= S_RST;
                        cpu_rst_q   <= 1'b1;
                        cpu_clk_q   <= 1'b0;
                        instr_q     <= '0;
                        phase_q     <= '0;
                        rst_cnt_q   <= '0;
                        rst_hi_q    <= 1'b0;
                        steps_q     <= '0;
                        halt_pc_q   <= 1'b0;
                        max_steps_q <= max_steps_i;
`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
                        step_seen_q <= 1'b0;
`endif
                    end
                end
                S_RST: begin
                    if (phase_q == PH_LAST) begin
                        phase_q <= '0;
                        if (!rst_hi_q) begin
                            rst_hi_q  <= 1'b1;
                            cpu_clk_q <= 1'b1;
                        end else begin
                            rst_hi_q  <= 1'b0;
                            cpu_clk_q <= 1'b0;
                            if (rst_cnt_q == RC_LAST) begin
                                state_q     <= S_LOW;
                                cpu_rst_q   <= 1'b0;
                                low_first_q <= 1'b1;
                            end else begin
                                rst_cnt_q <= rst_cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_LOW: begin
                    low_first_q <= 1'b0;
                    if (low_first_q && pc_oob) begin
                        state_q   <= S_DONE;
                        halt_pc_q <= 1'b1;
                        instr_q   <= '0;
                        cpu_clk_q <= 1'b0;
                    end else begin
                        // The fetch of the final LOW cycle is what the CPU sees at its rising edge.
                        instr_q <= fetch;
`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
                        if (step_req_i) step_seen_q <= 1'b1;
`endif
                        if (phase_q == PH_LAST) begin
                            if (step_ok) begin
                                state_q   <= S_HIGH;
                                cpu_clk_q <= 1'b1;
                                phase_q   <= '0;
`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
                                step_seen_q <= 1'b0;
`endif
                            end
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (phase_q == PH_LAST) begin
                        phase_q   <= '0;
                        cpu_clk_q <= 1'b0;
                        if (steps_q != 8'hFF) steps_q <= steps_q + 1'b1;
                        if ((max_steps_q != 8'd0) && (steps_inc == {1'b0, max_steps_q})) begin
                            state_q   <= S_DONE;
                            halt_pc_q <= 1'b0;
                            instr_q   <= '0;
                        end else begin
                            state_q     <= S_LOW;
                            low_first_q <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load.load_ready = load_rdy;
    assign cpu_io_in_o     = {instr_q, cpu_rst_q, cpu_clk_q};
    assign busy_o          = (state_q == S_RST) || (state_q == S_LOW) || (state_q == S_HIGH);
    assign done_o          = (state_q == S_DONE);
    assign halt_pc_o       = halt_pc_q;
    assign steps_o         = steps_q;
endmodule

// File: tb/tb_hidden_prog_feeder.sv
// Self-checking bench for hidden_prog_feeder: pc-model driven runs with an instruction scoreboard.
// Build with HIDDEN_FEEDER_SINGLE_STEP_EN to also exercise single-step gating.
module tb_hidden_prog_feeder;
    logic       clk = 1'b0;
    logic       rst;
    logic       run_start;
    logic [7:0] max_steps;
    logic [7:0] cpu_io_out;
    logic [7:0] cpu_io_in;
    logic       busy, done, halt_pc;
    logic [7:0] steps;
`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
    logic       step_req;
`endif

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [5:0] exp_q [$];
    logic [5:0] prog [16];

    hidden_prog_feeder_if lif ();

    hidden_prog_feeder #(.DEPTH(16), .HALF_CYC(2), .RST_CYC(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load         (lif),
        .run_start_i  (run_start),
        .max_steps_i  (max_steps),
`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
        .step_req_i   (step_req),
`endif
        .cpu_io_out_i (cpu_io_out),
        .cpu_io_in_o  (cpu_io_in),
        .busy_o       (busy),
        .done_o       (done),
        .halt_pc_o    (halt_pc),
        .steps_o      (steps)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic load_start_pulse();
        lif.load_start = 1'b1;
        @(negedge clk);
        lif.load_start = 1'b0;
    endtask

    task automatic load_word(input logic [5:0] d);
        lif.load_valid = 1'b1;
        lif.load_data  = d;
        @(negedge clk);
        lif.load_valid = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] ms);
        max_steps = ms;
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
    endtask

    // Models the CPU pc: mode 0 pc=step index, 1 stuck at 0, 2 branch 1 -> 7 -> 200.
    task automatic run_prog(input int mode, output int edges, output int rst_edges);
        logic       prev;
        logic [5:0] exp;
        int         pc;
        prev      = cpu_io_in[0];
        edges     = 0;
        rst_edges = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            if (cpu_io_in[0] && !prev) begin
                if (cpu_io_in[1]) begin
                    rst_edges++;
                end else begin
                    edges++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_mis++;
                        $display("FAIL sb_extra_edge: edge %0d instr=%h, required no edge", edges, cpu_io_in[7:2]);
                    end else begin
                        exp = exp_q.pop_front();
                        if (cpu_io_in[7:2] !== exp) begin
                            n_mis++;
                            $display("FAIL sb_instr: edge %0d instr=%h, required %h", edges, cpu_io_in[7:2], exp);
                        end
                    end
                    case (mode)
                        0: pc = edges;
                        1: pc = 0;
                        default: pc = (edges == 1) ? 1 : (edges == 2) ? 7 : 200;
                    endcase
                    cpu_io_out = 8'(pc);
                end
            end
            prev = cpu_io_in[0];
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_mis++;
            $display("FAIL run_timeout: done=%b after cycle budget, required 1", done);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL sb_leftover: %0d expected instrs unissued, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (cpu_io_in !== 8'h02) begin n_mis++; $display("FAIL rst_io: got %h, required 02", cpu_io_in); end
        n_cmp++; if (lif.load_ready !== 1'b1) begin n_mis++; $display("FAIL rst_ready: got %b, required 1", lif.load_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_mis++; $display("FAIL rst_done: got %b, required 0", done); end
        n_cmp++; if (halt_pc !== 1'b0) begin n_mis++; $display("FAIL rst_halt: got %b, required 0", halt_pc); end
        n_cmp++; if (steps !== 8'd0) begin n_mis++; $display("FAIL rst_steps: got %0d, required 0", steps); end
    endtask

    task automatic test_load_run();
        int e, re;
        load_start_pulse();
        load_word(6'h11); load_word(6'h22); load_word(6'h33);
        exp_q.push_back(6'h11); exp_q.push_back(6'h22); exp_q.push_back(6'h33);
        cpu_io_out = 8'd0;
        start_run(8'd0);
        run_prog(0, e, re);
        n_cmp++; if (e != 3) begin n_mis++; $display("FAIL lr_edges: got %0d, required 3", e); end
        n_cmp++; if (re != 2) begin n_mis++; $display("FAIL lr_rst_pulses: got %0d, required 2", re); end
        n_cmp++; if (halt_pc !== 1'b1) begin n_mis++; $display("FAIL lr_halt: got %b, required 1", halt_pc); end
        n_cmp++; if (steps !== 8'd3) begin n_mis++; $display("FAIL lr_steps: got %0d, required 3", steps); end
        n_cmp++; if (cpu_io_in !== 8'h00) begin n_mis++; $display("FAIL lr_done_io: got %h, required 00", cpu_io_in); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL lr_busy: got %b, required 0", busy); end
    endtask

    task automatic test_budget();
        int e, re;
        load_start_pulse();
        for (int i = 0; i < 16; i++) begin
            prog[i] = 6'(i * 5 + 3);
            load_word(prog[i]);
        end
        for (int i = 0; i < 5; i++) exp_q.push_back(prog[0]);
        cpu_io_out = 8'd0;
        start_run(8'd5);
        run_prog(1, e, re);
        n_cmp++; if (e != 5) begin n_mis++; $display("FAIL bud_edges: got %0d, required 5", e); end
        n_cmp++; if (halt_pc !== 1'b0) begin n_mis++; $display("FAIL bud_halt: got %b, required 0", halt_pc); end
        n_cmp++; if (steps !== 8'd5) begin n_mis++; $display("FAIL bud_steps: got %0d, required 5", steps); end
    endtask

    task automatic test_branch();
        int e, re;
        exp_q.push_back(prog[0]); exp_q.push_back(prog[1]); exp_q.push_back(prog[7]);
        cpu_io_out = 8'd0;
        start_run(8'd0);
        run_prog(2, e, re);
        n_cmp++; if (e != 3) begin n_mis++; $display("FAIL br_edges: got %0d, required 3", e); end
        n_cmp++; if (halt_pc !== 1'b1) begin n_mis++; $display("FAIL br_halt: got %b, required 1", halt_pc); end
        n_cmp++; if (steps !== 8'd3) begin n_mis++; $display("FAIL br_steps: got %0d, required 3", steps); end
    endtask

    task automatic test_boundary();
        int e, re;
        logic [5:0] w;
        load_start_pulse();
        for (int i = 0; i < 16; i++) begin
            w = 6'(i) ^ 6'h2A;
            n_cmp++;
            if (lif.load_ready !== 1'b1) begin n_mis++; $display("FAIL bd_ready_before: word %0d ready=%b, required 1", i, lif.load_ready); end
            load_word(w);
            exp_q.push_back(w);
        end
        n_cmp++; if (lif.load_ready !== 1'b0) begin n_mis++; $display("FAIL bd_ready_full: got %b, required 0", lif.load_ready); end
        load_word(6'h3F);
        cpu_io_out = 8'd0;
        start_run(8'd0);
        run_prog(0, e, re);
        n_cmp++; if (e != 16) begin n_mis++; $display("FAIL bd_edges: got %0d, required 16", e); end
        n_cmp++; if (steps !== 8'd16) begin n_mis++; $display("FAIL bd_steps: got %0d, required 16", steps); end
        n_cmp++; if (halt_pc !== 1'b1) begin n_mis++; $display("FAIL bd_halt: got %b, required 1", halt_pc); end
        lif.load_start = 1'b1; lif.load_valid = 1'b1; lif.load_data = 6'h05;
        @(negedge clk);
        lif.load_start = 1'b0; lif.load_valid = 1'b0;
        n_cmp++; if (lif.load_ready !== 1'b1) begin n_mis++; $display("FAIL bd_clear_ready: got %b, required 1", lif.load_ready); end
        cpu_io_out = 8'd0;
        start_run(8'd0);
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL bd_empty_run: busy=%b, required 0", busy); end
    endtask

`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
    task automatic count_edges(input int ncyc, inout int e);
        logic prev;
        prev = cpu_io_in[0];
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (cpu_io_in[0] && !prev && !cpu_io_in[1]) e++;
            prev = cpu_io_in[0];
        end
    endtask

    task automatic test_single_step();
        int e;
        e = 0;
        load_start_pulse();
        load_word(6'h11); load_word(6'h22);
        cpu_io_out = 8'd0;
        start_run(8'd0);
        count_edges(40, e);
        n_cmp++; if (e != 0) begin n_mis++; $display("FAIL ss_hold: edges=%0d, required 0", e); end
        step_req = 1'b1; @(negedge clk); step_req = 1'b0;
        count_edges(20, e);
        n_cmp++; if (e != 1) begin n_mis++; $display("FAIL ss_one: edges=%0d, required 1", e); end
        step_req = 1'b1; @(negedge clk); step_req = 1'b0;
        count_edges(20, e);
        n_cmp++; if (e != 2) begin n_mis++; $display("FAIL ss_two: edges=%0d, required 2", e); end
    endtask
`endif

    task automatic test_rst_mid();
        int  e;
        bit  seen;
        logic prev;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        load_start_pulse();
        load_word(6'h11); load_word(6'h22); load_word(6'h33);
        cpu_io_out = 8'd0;
        start_run(8'd0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (cpu_io_in[0] && !cpu_io_in[1]) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_mis++; $display("FAIL rm_high: HIGH phase seen=%b, required 1", seen); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (cpu_io_in !== 8'h02) begin n_mis++; $display("FAIL rm_io: got %h, required 02", cpu_io_in); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rm_busy: got %b, required 0", busy); end
        e = 0;
        prev = cpu_io_in[0];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_io_in[0] && !prev) e++;
            prev = cpu_io_in[0];
        end
        n_cmp++; if (e != 0) begin n_mis++; $display("FAIL rm_no_edges: got %0d, required 0", e); end
    endtask

    initial begin
        rst            = 1'b1;
        run_start      = 1'b0;
        max_steps      = 8'd0;
        cpu_io_out     = 8'd0;
        lif.load_start = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_data  = 6'd0;
`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
        step_req       = 1'b0;
`endif
        @(negedge clk);
        test_reset();
`ifdef HIDDEN_FEEDER_SINGLE_STEP_EN
        test_single_step();
        rst = 1'b1; @(negedge clk); rst = 1'b0;
`else
        test_load_run();
        test_budget();
        test_branch();
        test_boundary();
`endif
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
